matrix_store_reader: RTL and testbench
======================================

# matrix_store_reader

Read-side controller for `matrix_storage`, driving the read port that the write path leaves unused. It accepts a read request (dimensions plus index) and validates it. It then issues a storage read, waits for `rd_ready`, `err_rd` or a timeout, and captures the 200-bit matrix image. Finally it streams the elements row-major over a valid/ready byte interface to a downstream printer or calculation engine.

## Interface

**Parameters**
- `DATAWIDTH`, 8: bits per element; also the element stream width.
- `MAXDIM`, 5: maximum legal `m` and `n`.
- `TIMEOUT`, 1000: cycles to wait in WAIT before declaring a timeout; 16-bit counter.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req`, in, 1: single-cycle read request; sampled only in IDLE.
- `req_m`, in, 3: requested row count.
- `req_n`, in, 3: requested column count.
- `req_index`, in, 2: matrix slot within that dimension class.
- `read_en`, out, 1: one-cycle read strobe to storage.
- `rd_col`, out, 3: equals latched `req_m`; same role as the write side's `mat_col`.
- `rd_row`, out, 3: equals latched `req_n`.
- `rd_mat_index`, out, 2: latched `req_index`.
- `rd_data_flow`, in, 200: storage read data; valid in the cycle `rd_ready` is high.
- `rd_ready`, in, 1: storage read complete.
- `err_rd`, in, 1: storage reports no such matrix.
- `mat_flat`, out, 200: captured image; element k occupies bits [8k+7:8k], k = row*n + col.
- `mat_m`, out, 3: latched m.
- `mat_n`, out, 3: latched n.
- `mat_valid`, out, 1: one-cycle pulse when `mat_flat` is updated.
- `elem_data`, out, 8: streamed element.
- `elem_valid`, out, 1: stream valid.
- `elem_ready`, in, 1: consumer ready.
- `elem_last`, out, 1: high with the final element (k = m*n-1).
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last element is accepted.
- `error`, out, 1: one-cycle pulse on a failed request.
- `err_code`, out, 2: 01 bad dimensions, 10 storage error, 11 timeout; holds its value until the next `req`.

## Operation

**States:** IDLE, ISSUE, WAIT, STREAM.

**IDLE**
- On `req`, latch `req_m`, `req_n`, `req_index` and clear `err_code`.
- If m is 0, n is 0, m > MAXDIM or n > MAXDIM: pulse `error`, set `err_code` to 01 and stay in IDLE. No `read_en` is issued.
- Otherwise go to ISSUE.

**ISSUE**
- `read_en` = 1 for exactly one cycle.
- Go to WAIT and clear the timeout counter.
- `rd_col`, `rd_row` and `rd_mat_index` are held stable from ISSUE until leaving WAIT.

**WAIT**
- `err_rd` takes priority over `rd_ready` when both are high. On `err_rd`: pulse `error`, set `err_code` to 10, go to IDLE.
- Else on `rd_ready`: capture `rd_data_flow` into `mat_flat`, pulse `mat_valid`, clear element index k, go to STREAM.
- Else, when the counter reaches TIMEOUT-1: pulse `error`, set `err_code` to 11, go to IDLE.
- Otherwise increment the counter.

**STREAM**
- `elem_valid` = 1 and `elem_data` = `mat_flat`[8k+7:8k].
- `elem_last` = 1 when k equals m*n-1. Compute the product m*n as a 5-bit value; its maximum is 25.
- A handshake occurs when `elem_valid` and `elem_ready` are both high. On a handshake that is not the last element, k increments. On the last-element handshake, pulse `done` and go to IDLE.
- `elem_data` and `elem_last` must stay stable while `elem_valid` is high and `elem_ready` is low.
- Elements at k ≥ m*n are never emitted.

**General rules**
- `req` is ignored while `busy` is high; no queuing.
- Reset mid-operation aborts at once and no `done` or `error` is generated.
- The 1×1 case streams exactly one element, with `elem_last` high on it.

**Reset values:** all outputs are 0, `mat_flat` is 0, `err_code` is 00, state is IDLE.

## Timing

- `req` is sampled at edge 0. `read_en` is high in cycle 1. WAIT begins in cycle 2.
- Bad-dimension `error` is high in cycle 1; `busy` never rises.
- If `rd_ready` is high in WAIT cycle t, `mat_valid`, `elem_valid` and element 0 all appear in cycle t+1.
- With `elem_ready` tied high, one element is accepted per cycle. `done` comes one cycle after the last handshake, and `busy` is low in that same cycle.
- Timeout `error` comes exactly TIMEOUT cycles after WAIT is entered.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back requests: a new `req` is accepted in the cycle `busy` is low.

## Test plan

- Normal read: `req` with m=2, n=3, idx=1; `rd_ready` 4 cycles after `read_en`, data bytes 0x01..0x06. Required: `read_en` pulses once with `rd_col`=2, `rd_row`=3, `rd_mat_index`=1; the stream is 01,02,03,04,05,06 with `elem_last` on 06; `done` follows; `busy` returns to 0.
- Backpressure: 3×3 read with `elem_ready` toggling 1,0,0,1. Required: no element is dropped or duplicated; `elem_data` stays stable while stalled; 9 handshakes in total.
- Bad dimensions: `req` with m=0, n=3, then m=6, n=2. Required: `error` in cycle 1, `err_code`=01, `read_en` never asserted.
- Storage error: `err_rd` and `rd_ready` asserted together. Required: `error` pulse, `err_code`=10, no `mat_valid`, no stream.
- Timeout: TIMEOUT=20 and no response. Required: `error` 20 cycles after WAIT entry, `err_code`=11; a following valid `req` completes normally.
- Reset and ignore: assert `rst_n` low mid-STREAM of a 5×5 read. Required: all outputs go to 0 immediately and no `done`. A `req` pulsed during `busy` on the following read produces no second `read_en`.

Source files
------------

// File: rtl/matrix_store_reader.sv
// Read-side controller for matrix_storage: validates a read request, fetches the
// 200-bit matrix image and streams its elements row-major over a valid/ready port.
module matrix_store_reader #(
    parameter int DATAWIDTH = 8,
    parameter int MAXDIM    = 5,
    parameter int TIMEOUT   = 1000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req,
    input  logic [2:0]                            req_m,
    input  logic [2:0]                            req_n,
    input  logic [1:0]                            req_index,
    output logic                                  read_en,
    output logic [2:0]                            rd_col,
    output logic [2:0]                            rd_row,
    output logic [1:0]                            rd_mat_index,
    input  logic [MAXDIM*MAXDIM*DATAWIDTH-1:0]    rd_data_flow,
    input  logic                                  rd_ready,
    input  logic                                  err_rd,
    output logic [MAXDIM*MAXDIM*DATAWIDTH-1:0]    mat_flat,
    output logic [2:0]                            mat_m,
    output logic [2:0]                            mat_n,
    output logic                                  mat_valid,
    output logic [DATAWIDTH-1:0]                  elem_data,
    output logic                                  elem_valid,
    input  logic                                  elem_ready,
    output logic                                  elem_last,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  error,
    output logic [1:0]                            err_code,
    output logic [1:0]                            fsm_state
);

    localparam int ELEMS  = MAXDIM * MAXDIM;
    localparam int FLAT_W = ELEMS * DATAWIDTH;
    localparam int K_W    = $clog2(ELEMS);
    localparam logic [2:0]  MAX_D   = 3'(MAXDIM);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [2:0]          m_q, m_d, n_q, n_d;
    logic [1:0]          idx_q, idx_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [FLAT_W-1:0]   flat_q, flat_d;
    logic                mat_valid_q, mat_valid_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [K_W-1:0]      prod;
    logic [K_W-1:0]      last_k;
    logic                bad_dims;
    logic [DATAWIDTH-1:0] elems [0:ELEMS-1];

    assign bad_dims = (req_m == 3'd0) || (req_n == 3'd0) || (req_m > MAX_D) || (req_n > MAX_D);
    assign prod     = K_W'(m_q) * K_W'(n_q);
    assign last_k   = prod - K_W'(1);

    always_comb begin
        for (int i = 0; i < ELEMS; i++) begin
            elems[i] = flat_q[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            m_q         <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            k_q         <= '0;
            flat_q      <= '0;
            mat_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state       <= state_next;
            m_q         <= m_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            flat_q      <= flat_d;
            mat_valid_q <= mat_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_next  = state;
        m_d         = m_q;
        n_d         = n_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        flat_d      = flat_q;
        mat_valid_d = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        case (state)
            IDLE: begin
                if (req) begin
                    m_d        = req_m;
                    n_d        = req_n;
                    idx_d      = req_index;
                    err_code_d = 2'b00;
                    if (bad_dims) begin
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d      = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A storage error wins even if the data strobe arrives with it.
                if (err_rd) begin
                    error_d    = 1'b1;
                    err_code_d = 2'b10;
                    state_next = IDLE;
                end else if (rd_ready) begin
                    flat_d      = rd_data_flow;
                    mat_valid_d = 1'b1;
                    k_d         = '0;
                    state_next  = STREAM;
                end else if (cnt_q == TO_LAST) begin
                    error_d    = 1'b1;
                    err_code_d = 2'b11;
                    state_next = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STREAM: begin
                if (elem_ready) begin
                    if (k_q == last_k) begin
                        done_d     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stream outputs are decoded from registered state only, so they hold under stall.
    assign read_en      = (state == ISSUE);
    assign busy         = (state != IDLE);
    assign elem_valid   = (state == STREAM);
    assign elem_last    = (state == STREAM) && (k_q == last_k);
    assign elem_data    = (state == STREAM) ? elems[k_q] : '0;
    assign rd_col       = m_q;
    assign rd_row       = n_q;
    assign rd_mat_index = idx_q;
    assign mat_m        = m_q;
    assign mat_n        = n_q;
    assign mat_flat     = flat_q;
    assign mat_valid    = mat_valid_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_matrix_store_reader.sv
// Directed bench for matrix_store_reader: normal read, backpressure, bad dimensions,
// storage error, timeout, reset mid-stream and request-while-busy.
module tb_matrix_store_reader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [2:0]   req_m, req_n;
    logic [1:0]   req_index;
    logic         read_en;
    logic [2:0]   rd_col, rd_row;
    logic [1:0]   rd_mat_index;
    logic [199:0] rd_data_flow;
    logic         rd_ready, err_rd;
    logic [199:0] mat_flat;
    logic [2:0]   mat_m, mat_n;
    logic         mat_valid;
    logic [7:0]   elem_data;
    logic         elem_valid, elem_ready, elem_last;
    logic         busy, done, error;
    logic [1:0]   err_code;
    logic [1:0]   fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    int read_en_cnt = 0, mat_valid_cnt = 0, done_cnt = 0, hs_cnt = 0, stall_bad = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    matrix_store_reader #(.DATAWIDTH(8), .MAXDIM(5), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_m(req_m), .req_n(req_n),
        .req_index(req_index), .read_en(read_en), .rd_col(rd_col), .rd_row(rd_row),
        .rd_mat_index(rd_mat_index), .rd_data_flow(rd_data_flow), .rd_ready(rd_ready),
        .err_rd(err_rd), .mat_flat(mat_flat), .mat_m(mat_m), .mat_n(mat_n),
        .mat_valid(mat_valid), .elem_data(elem_data), .elem_valid(elem_valid),
        .elem_ready(elem_ready), .elem_last(elem_last), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge: pulse counts, accepted elements, stall stability.
    always @(negedge clk) begin
        if (read_en) read_en_cnt++;
        if (mat_valid) mat_valid_cnt++;
        if (done) done_cnt++;
        if (prev_stall && ((elem_data !== prev_data) || (elem_last !== prev_last) || !elem_valid))
            stall_bad++;
        if (elem_valid && elem_ready) begin
            hs_cnt++;
            got_q.push_back({elem_last, elem_data});
        end
        prev_stall = elem_valid && !elem_ready;
        prev_data  = elem_data;
        prev_last  = elem_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [2:0] m, input logic [2:0] n, input logic [1:0] idx);
        req = 1'b1; req_m = m; req_n = n; req_index = idx;
        step();
        req = 1'b0;
    endtask

    function automatic logic [199:0] make_data(input int base, input int count);
        logic [199:0] d = '0;
        for (int k = 0; k < count; k++) d[k*8 +: 8] = 8'(base + k);
        return d;
    endfunction

    task automatic expect_stream(input int base, input int count);
        for (int k = 0; k < count; k++)
            exp_q.push_back({(k == count - 1) ? 1'b1 : 1'b0, 8'(base + k)});
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, 200'(got_q.size()), 200'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_elem"}, 200'(got_q.pop_front()), 200'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        chk({tag, "_done"}, 200'(done), 200'(1));
        chk({tag, "_busy_at_done"}, 200'(busy), 200'(0));
    endtask

    initial begin
        int re0, mv0, hs0, dn0;
        logic [3:0] pat;
        rst_n = 1'b0; req = 1'b0; req_m = '0; req_n = '0; req_index = '0;
        rd_data_flow = '0; rd_ready = 1'b0; err_rd = 1'b0; elem_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_busy", 200'(busy), 200'(0));
        chk("rst_read_en", 200'(read_en), 200'(0));
        chk("rst_mat_flat", mat_flat, 200'(0));
        chk("rst_err_code", 200'(err_code), 200'(0));
        chk("rst_elem_valid", 200'(elem_valid), 200'(0));
        chk("rst_done_error", 200'({done, error, mat_valid}), 200'(0));
        rst_n = 1'b1;
        step();

        // Normal read 2x3, rd_ready four cycles after read_en
        re0 = read_en_cnt;
        rd_data_flow = make_data(1, 6);
        elem_ready = 1'b1;
        expect_stream(1, 6);
        send_req(3'd2, 3'd3, 2'd1);
        chk("norm_read_en", 200'(read_en), 200'(1));
        chk("norm_rd_addr", 200'({rd_col, rd_row, rd_mat_index}), 200'({3'd2, 3'd3, 2'd1}));
        chk("norm_busy", 200'(busy), 200'(1));
        step();
        chk("norm_read_en_off", 200'(read_en), 200'(0));
        step(); step(); step();
        chk("norm_addr_held", 200'({rd_col, rd_row, rd_mat_index}), 200'({3'd2, 3'd3, 2'd1}));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("norm_mat_valid", 200'(mat_valid), 200'(1));
        chk("norm_first_elem", 200'({elem_valid, elem_data}), 200'({1'b1, 8'h01}));
        chk("norm_mat_flat", mat_flat, make_data(1, 6));
        chk("norm_mat_mn", 200'({mat_m, mat_n}), 200'({3'd2, 3'd3}));
        step();
        chk("norm_mat_valid_pulse", 200'(mat_valid), 200'(0));
        wait_done("norm", 20);
        check_stream("norm");
        chk("norm_read_en_once", 200'(read_en_cnt - re0), 200'(1));
        step();
        chk("norm_done_pulse", 200'(done), 200'(0));

        // Backpressure 3x3 with ready pattern 1,0,0,1
        hs0 = hs_cnt;
        rd_data_flow = make_data(8'hA0, 9);
        expect_stream(8'hA0, 9);
        send_req(3'd3, 3'd3, 2'd2);
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        pat = 4'b1001;
        for (int i = 0; i < 80 && done !== 1'b1; i++) begin
            elem_ready = pat[3 - (i % 4)];
            step();
        end
        chk("bp_done", 200'(done), 200'(1));
        chk("bp_handshakes", 200'(hs_cnt - hs0), 200'(9));
        chk("bp_stall_stable", 200'(stall_bad), 200'(0));
        check_stream("bp");
        elem_ready = 1'b1;
        step();

        // Bad dimensions
        re0 = read_en_cnt;
        send_req(3'd0, 3'd3, 2'd0);
        chk("bad0_error", 200'(error), 200'(1));
        chk("bad0_code", 200'(err_code), 200'(1));
        chk("bad0_busy", 200'(busy), 200'(0));
        step();
        chk("bad0_error_pulse", 200'(error), 200'(0));
        chk("bad0_code_hold", 200'(err_code), 200'(1));
        send_req(3'd6, 3'd2, 2'd0);
        chk("bad6_error", 200'(error), 200'(1));
        chk("bad6_code", 200'(err_code), 200'(1));
        step(); step();
        chk("bad_no_read_en", 200'(read_en_cnt - re0), 200'(0));
        chk("bad_idle", 200'(busy), 200'(0));

        // Storage error together with rd_ready
        mv0 = mat_valid_cnt; hs0 = hs_cnt;
        send_req(3'd2, 3'd2, 2'd0);
        chk("serr_code_cleared", 200'(err_code), 200'(0));
        step();
        err_rd = 1'b1; rd_ready = 1'b1;
        step();
        err_rd = 1'b0; rd_ready = 1'b0;
        chk("serr_error", 200'(error), 200'(1));
        chk("serr_code", 200'(err_code), 200'(2));
        chk("serr_no_stream", 200'({elem_valid, busy}), 200'(0));
        step(); step();
        chk("serr_no_mat_valid", 200'(mat_valid_cnt - mv0), 200'(0));
        chk("serr_no_handshake", 200'(hs_cnt - hs0), 200'(0));

        // Timeout (20 cycles after WAIT entry)
        send_req(3'd1, 3'd1, 2'd3);
        step();
        for (int i = 0; i < 19; i++) step();
        chk("to_not_yet", 200'({error, busy}), 200'({1'b0, 1'b1}));
        step();
        chk("to_error", 200'(error), 200'(1));
        chk("to_code", 200'(err_code), 200'(3));
        chk("to_idle", 200'(busy), 200'(0));

        // Following 1x1 read completes normally
        rd_data_flow = make_data(8'h5A, 1);
        expect_stream(8'h5A, 1);
        send_req(3'd1, 3'd1, 2'd0);
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("one_elem", 200'({elem_valid, elem_last, elem_data}), 200'({1'b1, 1'b1, 8'h5A}));
        chk("one_code_cleared", 200'(err_code), 200'(0));
        step();
        chk("one_done", 200'({done, busy, elem_valid}), 200'({1'b1, 1'b0, 1'b0}));
        check_stream("one");

        // Reset mid-stream of a 5x5 read
        rd_data_flow = make_data(8'h10, 25);
        send_req(3'd5, 3'd5, 2'd2);
        step();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        step(); step(); step();
        chk("rst5_streaming", 200'({elem_valid, elem_data}), 200'({1'b1, 8'h13}));
        dn0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("rst5_outputs", 200'({busy, elem_valid, elem_data, elem_last, read_en, mat_m, mat_n, err_code}), 200'(0));
        chk("rst5_mat_flat", mat_flat, 200'(0));
        step(); step();
        rst_n = 1'b1;
        step(); step();
        chk("rst5_no_done", 200'(done_cnt - dn0), 200'(0));
        got_q.delete();

        // req while busy is ignored
        re0 = read_en_cnt;
        rd_data_flow = make_data(8'h30, 4);
        expect_stream(8'h30, 4);
        send_req(3'd2, 3'd2, 2'd1);
        step();
        send_req(3'd3, 3'd3, 2'd0);
        chk("ign_addr_held", 200'({rd_col, rd_row, rd_mat_index}), 200'({3'd2, 3'd2, 2'd1}));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        wait_done("ign", 20);
        check_stream("ign");
        step(); step();
        chk("ign_one_read_en", 200'(read_en_cnt - re0), 200'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
